// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port round-robin arbiter in front of a single memory line port.
// One 256-bit line transaction is serialised at a time. The granted request is
// latched, so the memory sees a stable op/address/wdata for the whole transaction.
// Optional macro ARB_FIXED_PRIORITY_EN: removes the round-robin pointer and always
// scans from port 0, so the lowest index wins (debug / I-fetch-first runs).
//
// state | meaning
// IDLE  | no transaction in flight; pick the next pending port
// BUSY  | latched transaction presented to memory; wait for mem_resp
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [NUM_PORTS*LINE_WIDTH-1:0]  req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_resp,
    input  logic [LINE_WIDTH-1:0]            mem_rdata
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PTR_W-1:0]       grant;
    logic [PTR_W-1:0]       scan_start;
    logic [PTR_W-1:0]       sel_idx;
    logic                   sel_valid;
    int                     scan_idx;
    logic                   lat_write;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [LINE_WIDTH-1:0]  lat_wdata;
    logic [NUM_PORTS-1:0]   pending;
    logic                   done;

    assign pending = req_read | req_write;
    assign done    = (state == BUSY) && mem_resp;

`ifdef ARB_FIXED_PRIORITY_EN
    assign scan_start = '0;
`else
    logic [PTR_W-1:0] rr_ptr;

    // Round-robin pointer: the port after the one just served goes first next time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (done) begin
            rr_ptr <= (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + PTR_W'(1);
        end
    end

    assign scan_start = rr_ptr;
`endif

    // Pick the first pending port starting at scan_start; iterating from the far
    // end backwards lets the closest pending port overwrite the others.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            scan_idx = (int'(scan_start) + k) % NUM_PORTS;
            if (pending[scan_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winning request so later input changes cannot disturb memory.
    // Read+write together is treated as a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if ((state == IDLE) && sel_valid) begin
            grant     <= sel_idx;
            lat_write <= req_write[sel_idx];
            lat_addr  <= req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= req_wdata[int'(sel_idx)*LINE_WIDTH +: LINE_WIDTH];
        end
    end

    // Next state and all outputs; response is routed to the granted port only.
    always_comb begin
        state_nxt = state;
        req_resp  = '0;
        req_rdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_read  = ~lat_write;
                mem_write = lat_write;
                if (mem_resp) begin
                    state_nxt       = IDLE;
                    req_resp[grant] = 1'b1;
                    if (!lat_write) begin
                        req_rdata[int'(grant)*LINE_WIDTH +: LINE_WIDTH] = mem_rdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-port instance for the main scenarios and
// a 4-port instance for pointer-based selection. Expectations follow the build's
// ARB_FIXED_PRIORITY_EN setting.
module tb_mem_arbiter_rr;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      rd2, wr2, resp2;
    logic [2*AW-1:0] addr2;
    logic [2*LW-1:0] wdata2, rdata2;
    logic            m_rd2, m_wr2, m_resp2;
    logic [AW-1:0]   m_addr2;
    logic [LW-1:0]   m_wdata2, m_rdata2;

    logic [3:0]      rd4, wr4, resp4;
    logic [4*AW-1:0] addr4;
    logic [4*LW-1:0] wdata4, rdata4;
    logic            m_rd4, m_wr4, m_resp4;
    logic [AW-1:0]   m_addr4;
    logic [LW-1:0]   m_wdata4, m_rdata4;

    mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_read(rd2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
        .req_resp(resp2), .req_rdata(rdata2),
        .mem_read(m_rd2), .mem_write(m_wr2), .mem_addr(m_addr2), .mem_wdata(m_wdata2),
        .mem_resp(m_resp2), .mem_rdata(m_rdata2)
    );

    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_read(rd4), .req_write(wr4), .req_addr(addr4), .req_wdata(wdata4),
        .req_resp(resp4), .req_rdata(rdata4),
        .mem_read(m_rd4), .mem_write(m_wr4), .mem_addr(m_addr4), .mem_wdata(m_wdata4),
        .mem_resp(m_resp4), .mem_rdata(m_rdata4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory model and monitor state for dut2
    bit          auto_mem = 0;
    int          mlat = 1;
    int          mcnt = 0;
    logic [LW-1:0] mpat = '0;
    int          grants[$];
    int          gaps[$];
    bit          prev_strobe = 0;
    bit          have_prev = 0;
    int          idle_run = 0;

    int          exp_g[5];
    int          first4, second4;
    int          nresp;
    logic [LW-1:0] wx;

    task automatic check_val(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: memory model answers at the falling edge, outputs sampled 1ns later.
    task automatic tick();
        bit strobe;
        @(negedge clk);
        if (auto_mem) begin
            m_resp2  = 1'b0;
            m_rdata2 = '0;
            if (m_rd2 | m_wr2) begin
                mcnt++;
                if (mcnt == mlat) begin
                    m_resp2  = 1'b1;
                    m_rdata2 = mpat;
                    mcnt     = 0;
                end
            end
        end
        #1;
        strobe = m_rd2 | m_wr2;
        if (strobe && !prev_strobe) begin
            if (have_prev) gaps.push_back(idle_run);
            have_prev = 1;
        end
        idle_run    = strobe ? 0 : idle_run + 1;
        prev_strobe = strobe;
        if (resp2 != 2'b00) grants.push_back(resp2[1] ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rd2 = 2'b11; wr2 = '0; addr2 = {32'h0000_2000, 32'h0000_1000}; wdata2 = '0;
        m_resp2 = 1'b0; m_rdata2 = '0;
        rd4 = '0; wr4 = '0; wdata4 = '0; m_resp4 = 1'b0; m_rdata4 = '0;
        addr4 = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
`ifdef ARB_FIXED_PRIORITY_EN
        exp_g = '{0, 0, 0, 0, 1};
        first4 = 1; second4 = 3;
`else
        exp_g = '{0, 1, 0, 1, 1};
        first4 = 3; second4 = 1;
`endif

        // reset with requests held
        tick();
        tick();
        check_val("rst_mem_read",  LW'(m_rd2), LW'(0));
        check_val("rst_mem_write", LW'(m_wr2), LW'(0));
        check_val("rst_req_resp",  LW'(resp2), LW'(0));
        check_val("rst_mem_addr",  LW'(m_addr2), LW'(0));
        check_val("rst_dut4_read", LW'(m_rd4), LW'(0));
        rst_n = 1'b1;
        tick();
        check_val("rel_mem_read", LW'(m_rd2), LW'(1));
        check_val("rel_mem_addr", LW'(m_addr2), LW'(32'h1000));
        m_resp2 = 1'b1;
        #1;
        check_val("rel_resp", LW'(resp2), LW'(2'b01));
        rd2 = 2'b00;
        tick();
        m_resp2 = 1'b0;
        check_val("rel_bubble", LW'(m_rd2), LW'(0));

        // single read on port 1, 5-cycle memory
        auto_mem = 1; mlat = 5; mcnt = 0; mpat = {32{8'hA5}};
        addr2[63:32] = 32'h0000_0040;
        rd2 = 2'b10;
        nresp = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (resp2 != 2'b00) begin
                nresp++;
                check_val("single_resp",   LW'(resp2), LW'(2'b10));
                check_val("single_rdata1", rdata2[511:256], {32{8'hA5}});
                check_val("single_rdata0", rdata2[255:0], LW'(0));
                check_val("single_addr",   LW'(m_addr2), LW'(32'h40));
                rd2 = 2'b00;
            end
        end
        check_val("single_resp_count", LW'(nresp), LW'(1));

        // contention with 3-cycle memory
        grants.delete(); gaps.delete(); have_prev = 0;
        mlat = 3; mcnt = 0;
        addr2 = {32'h0000_0300, 32'h0000_0200};
        rd2 = 2'b11;
        for (int i = 0; i < 60 && grants.size() < 5; i++) begin
            tick();
            if (resp2 != 2'b00 && grants.size() == 4) rd2[0] = 1'b0;
            if (resp2 != 2'b00 && grants.size() == 5) rd2 = 2'b00;
        end
        rd2 = 2'b00;
        check_val("cont_grant_count", LW'(grants.size()), LW'(5));
        for (int i = 0; i < 5; i++)
            if (grants.size() > i) check_val($sformatf("cont_grant%0d", i), LW'(grants[i]), LW'(exp_g[i]));
        check_val("cont_gap_count", LW'(gaps.size()), LW'(4));
        for (int i = 0; i < 4; i++)
            if (gaps.size() > i) check_val($sformatf("cont_gap%0d", i), LW'(gaps[i]), LW'(1));
        tick();
        tick();

        // write latching: inputs change after grant
        auto_mem = 0; m_resp2 = 1'b0; m_rdata2 = '0;
        wx = {8{32'hDEAD_BEEF}};
        addr2[63:32] = 32'h0000_0100; wdata2[511:256] = wx;
        wr2 = 2'b10;
        tick();
        check_val("wr_mem_write", LW'(m_wr2), LW'(1));
        check_val("wr_mem_read",  LW'(m_rd2), LW'(0));
        check_val("wr_addr0",     LW'(m_addr2), LW'(32'h100));
        addr2[63:32] = 32'h0000_0999; wdata2[511:256] = ~wx;
        tick();
        check_val("wr_addr1",  LW'(m_addr2), LW'(32'h100));
        check_val("wr_wdata1", m_wdata2, wx);
        tick();
        m_resp2 = 1'b1; m_rdata2 = {32{8'h5A}};
        #1;
        check_val("wr_resp",    LW'(resp2), LW'(2'b10));
        check_val("wr_wdata2",  m_wdata2, wx);
        check_val("wr_rdata1",  rdata2[511:256], LW'(0));
        wr2 = 2'b00;
        tick();
        m_resp2 = 1'b0; m_rdata2 = '0;
        check_val("wr_done", LW'(m_wr2), LW'(0));

        // read+write on one port is a write
        addr2[31:0] = 32'h0000_0500;
        rd2 = 2'b01; wr2 = 2'b01;
        tick();
        check_val("rw_mem_write", LW'(m_wr2), LW'(1));
        check_val("rw_mem_read",  LW'(m_rd2), LW'(0));
        check_val("rw_addr",      LW'(m_addr2), LW'(32'h500));
        m_resp2 = 1'b1;
        #1;
        check_val("rw_resp", LW'(resp2), LW'(2'b01));
        rd2 = 2'b00; wr2 = 2'b00;
        tick();
        m_resp2 = 1'b0;

        // spurious mem_resp in IDLE
        m_resp2 = 1'b1; m_rdata2 = {32{8'hFF}};
        #1;
        check_val("spur_resp",  LW'(resp2), LW'(0));
        check_val("spur_rdata", rdata2[255:0], LW'(0));
        tick();
        m_resp2 = 1'b0; m_rdata2 = '0;
        check_val("spur_idle", LW'(m_rd2 | m_wr2), LW'(0));

        // 4 ports: serve port 1 to move the pointer to 2, then ports 1 and 3 pending
        rd4 = 4'b0010;
        tick();
        check_val("p4_pre_addr", LW'(m_addr4), LW'(32'h2000));
        m_resp4 = 1'b1;
        #1;
        check_val("p4_pre_resp", LW'(resp4), LW'(4'b0010));
        rd4 = 4'b0000;
        tick();
        m_resp4 = 1'b0;
        rd4 = 4'b1010;
        tick();
        check_val("p4_first_addr", LW'(m_addr4), LW'(32'h1000 * (first4 + 1)));
        m_resp4 = 1'b1; m_rdata4 = {32{8'h3C}};
        #1;
        check_val("p4_first_resp",  LW'(resp4), LW'(4'b0001 << first4));
        check_val("p4_first_rdata", rdata4[first4*LW +: LW], {32{8'h3C}});
        check_val("p4_other_rdata", rdata4[second4*LW +: LW], LW'(0));
        rd4[first4] = 1'b0;
        tick();
        m_resp4 = 1'b0; m_rdata4 = '0;
        tick();
        check_val("p4_second_addr", LW'(m_addr4), LW'(32'h1000 * (second4 + 1)));
        m_resp4 = 1'b1;
        #1;
        check_val("p4_second_resp", LW'(resp4), LW'(4'b0001 << second4));
        rd4 = 4'b0000;
        tick();
        m_resp4 = 1'b0;

        // reset during BUSY drops the strobe
        addr2[63:32] = 32'h0000_0040;
        rd2 = 2'b10;
        tick();
        check_val("rstbusy_read", LW'(m_rd2), LW'(1));
        rst_n = 1'b0;
        tick();
        check_val("rstbusy_drop", LW'(m_rd2), LW'(0));
        check_val("rstbusy_addr", LW'(m_addr2), LW'(0));
        rst_n = 1'b1;
        rd2 = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
